spi_cmd_regbank: RTL and testbench
==================================

Name: spi_cmd_regbank

Overview:
- Byte-level command decoder and register bank directly downstream of the SPI slave.
- Consumes each received byte (slave data_out / data_out_valid) framed by the slave's busy signal.
- Decodes a 1-byte command header, writes or reads an internal byte-register bank with address auto-increment, and returns response bytes through the slave's data_in / data_in_valid.
- Register contents drive board outputs (LEDs, GPIO control) through a flat output bus.

Parameters:
- NUM_REGS, 8, number of 8-bit registers; legal 2..127.
- RESET_VALUE, 8'h00, reset value of every register.
- ERR_BYTE, 8'hEE, response byte for an illegal address.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  byte received from the SPI slave.
- rx_valid  input  1  one-clk pulse; rx_data is valid.
- frame_active  input  1  slave busy; high while chip select is asserted.
- tx_data  output  8  next byte for the slave to shift out on MISO.
- tx_valid  output  1  one-clk pulse; tx_data loaded.
- regs_o  output  NUM_REGS*8  register bank, reg[i] at bits [8i+7:8i].
- wr_strobe  output  1  one-clk pulse per register write.
- wr_addr  output  7  address written on wr_strobe.
- err_count  output  8  saturating count of illegal-address commands.

Behaviour:
Reset (async):
- State = IDLE, addr = 0, every reg = RESET_VALUE.
- tx_data = 8'h00; tx_valid, wr_strobe = 0; wr_addr = 0; err_count = 0.

Command byte:
- bit7 = 1 means write; bit7 = 0 means read.
- bits[6:0] = start address.

States: IDLE, WRITE, READ, DROP.
- IDLE, on rx_valid:
  - Latch addr = rx_data[6:0].
  - If addr >= NUM_REGS: go to DROP, err_count++ (saturate at 255), and pulse tx_valid with tx_data = ERR_BYTE next cycle.
  - Else if write: go to WRITE. No tx_valid.
  - Else (read): go to READ, and pulse tx_valid with tx_data = reg[addr] on the next cycle (1-clk latency); then addr = addr+1.
- WRITE, on each rx_valid:
  - reg[addr] <= rx_data, visible on regs_o the next cycle.
  - wr_strobe = 1 and wr_addr = addr for that cycle.
  - addr increments and wraps NUM_REGS-1 -> 0.
- READ, on each rx_valid (dummy byte, value ignored):
  - Next cycle: tx_data = reg[addr], tx_valid = 1.
  - addr increments with wrap.
  - Read data is sampled at the rx_valid cycle; a same-cycle write is impossible (single stream).
- DROP: every rx_valid ignored; no tx_valid, no writes.

Frame end:
- A falling edge of frame_active, detected with a 1-flop registered copy, forces IDLE in every state.
- If rx_valid coincides with the falling edge, that byte is processed first (write or read still happens) and the state still returns to IDLE.
- rx_valid while frame_active = 0 and not on the edge cycle is treated as a new command (robust to slave timing).

Other rules:
- tx_data holds its value between pulses.
- tx_valid and wr_strobe are never high for more than 1 cycle.
- Reset mid-frame: everything returns to reset values immediately. The next frame must start with a fresh command byte.
- Width: addr is 7 bits. Wrap compare is addr == NUM_REGS-1.

Decomposition:
- Package spi_cmd_pkg holds:
  - state enum {IDLE, WRITE, READ, DROP};
  - CMD_WRITE_BIT = 7;
  - ADDR_W = 7;
  - default ERR_BYTE.
- One sub-module is natural: spi_frame_edge, a registered falling-edge detector on frame_active producing a 1-clk frame_end pulse.
- The register bank remains inline.

Test Plan:
- Write burst: frame of 0x81, 0xAA, 0x55 (NUM_REGS = 8) -> reg1 = 0xAA, reg2 = 0x55; wr_strobe twice with wr_addr 1 then 2; no tx_valid.
- Read burst: after the write burst, frame of 0x01, 0x00, 0x00 -> three tx_valid pulses, each 1 clk after its rx_valid, with tx_data 0xAA, 0x55, reg3 = 0x00.
- Wrap: write frame 0x87, 0x11, 0x22 -> reg7 = 0x11, reg0 = 0x22; the next wr_addr after 7 is 0.
- Illegal address: frame 0x0A, 0x00 -> one tx_valid with 0xEE, then silence; err_count = 1; regs_o unchanged. 256 such frames leave err_count at 255.
- Frame abort: 0x83, then drop frame_active before the data byte, then a new frame 0x03, 0x00 -> byte 0x03 is parsed as a read command; tx_data = reg3, not written.
- Async reset: assert rst mid-WRITE between clock edges -> regs_o all RESET_VALUE and tx_valid = 0 immediately; after release, a fresh frame 0x82, 0x5A sets reg2 = 0x5A.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder / register bank.
//   state_t          : command FSM states
//   CMD_WRITE_BIT    : command byte bit selecting write (1) or read (0)
//   ADDR_W           : width of the register address field
//   ERR_BYTE_DEFAULT : response byte for an illegal start address
//   addr_inc()       : address increment with wrap at num_regs-1
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DROP  = 2'd3
  } state_t;

  localparam int         CMD_WRITE_BIT    = 7;
  localparam int         ADDR_W           = 7;
  localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

  // Bursts walk the bank and roll over from the last register back to 0.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr,
                                                 input int                num_regs);
    return (addr == ADDR_W'(num_regs - 1)) ? '0 : addr + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_frame_edge.sv
// Registered falling-edge detector on the SPI slave busy signal.
//   clk            : system clock
//   rst            : asynchronous active-high reset
//   i_frame_active : slave busy, high while chip select is asserted
//   o_frame_end    : one-clk pulse on the first cycle frame_active is seen low
module spi_frame_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_frame_active,
  output logic o_frame_end
);

  logic r_frame_d;

  // NOTE: state elements use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_d <= 1'b0;
    else     r_frame_d <= i_frame_active;
  end

  assign o_frame_end = r_frame_d & ~i_frame_active;

endmodule

// File: rtl/spi_cmd_regbank.sv
// Byte-level command decoder and register bank behind an SPI slave.
// A frame starts with a command byte {rw, addr[6:0]}; rw=1 writes the
// following bytes to consecutive registers, rw=0 returns consecutive
// registers (one per received byte). Illegal start addresses answer ERR_BYTE
// once and ignore the rest of the frame.
//   clk, rst      : system clock, asynchronous active-high reset
//   rx_data       : byte received from the slave, valid with rx_valid
//   rx_valid      : one-clk strobe
//   frame_active  : slave busy (chip select asserted)
//   tx_data       : response byte for the slave, held between pulses
//   tx_valid      : one-clk strobe, tx_data just loaded
//   regs_o        : flat register bank, reg[i] at [8i+7:8i]
//   wr_strobe     : one-clk pulse per register write (with wr_addr)
//   wr_addr       : address of the register just written
//   err_count     : saturating count of illegal-address commands
module spi_cmd_regbank
  import spi_cmd_pkg::*;
#(
  parameter int         NUM_REGS    = 8,
  parameter logic [7:0] RESET_VALUE = 8'h00,
  parameter logic [7:0] ERR_BYTE    = ERR_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  frame_active,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            err_count
);

  state_t                r_state;
  logic [ADDR_W-1:0]     r_addr;
  logic [NUM_REGS*8-1:0] r_regs;

  state_t                w_state_nxt;
  logic [ADDR_W-1:0]     w_addr_nxt;
  logic [ADDR_W-1:0]     w_cmd_addr;
  logic                  w_cmd_legal;
  logic                  w_tx_load;
  logic [7:0]            w_tx_byte;
  logic                  w_wr_en;
  logic                  w_err_inc;
  logic                  w_frame_end;

  spi_frame_edge u_frame_edge (
    .clk            (clk),
    .rst            (rst),
    .i_frame_active (frame_active),
    .o_frame_end    (w_frame_end)
  );

  assign w_cmd_addr  = rx_data[ADDR_W-1:0];
  assign w_cmd_legal = (w_cmd_addr < ADDR_W'(NUM_REGS));

  // Next-state and per-byte actions. The byte arriving on the frame-end cycle
  // is still acted on; only the state is overridden back to IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and infers a latch.
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_tx_load   = 1'b0;
    w_tx_byte   = 8'h00;
    w_wr_en     = 1'b0;
    w_err_inc   = 1'b0;

    if (rx_valid) begin
      unique case (r_state)
        IDLE: begin
          w_addr_nxt = w_cmd_addr;
          if (!w_cmd_legal) begin
            w_state_nxt = DROP;
            w_err_inc   = 1'b1;
            w_tx_load   = 1'b1;
            w_tx_byte   = ERR_BYTE;
          end else if (rx_data[CMD_WRITE_BIT]) begin
            w_state_nxt = WRITE;
          end else begin
            // The command byte itself triggers the first read response.
            w_state_nxt = READ;
            w_tx_load   = 1'b1;
            w_tx_byte   = r_regs[int'(w_cmd_addr)*8 +: 8];
            w_addr_nxt  = addr_inc(w_cmd_addr, NUM_REGS);
          end
        end
        WRITE: begin
          w_wr_en    = 1'b1;
          w_addr_nxt = addr_inc(r_addr, NUM_REGS);
        end
        READ: begin
          w_tx_load  = 1'b1;
          w_tx_byte  = r_regs[int'(r_addr)*8 +: 8];
          w_addr_nxt = addr_inc(r_addr, NUM_REGS);
        end
        DROP: ;
        default: w_state_nxt = IDLE;
      endcase
    end

    if (w_frame_end) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the bank is reset because its contents drive board outputs
      // directly; it must come up at a known value, not be an unreset RAM.
      r_regs    <= {NUM_REGS{RESET_VALUE}};
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      err_count <= 8'h00;
    end else begin
      tx_valid  <= w_tx_load;
      wr_strobe <= w_wr_en;
      if (w_tx_load) tx_data <= w_tx_byte;
      if (w_wr_en) begin
        r_regs[int'(r_addr)*8 +: 8] <= rx_data;
        wr_addr                     <= r_addr;
      end
      if (w_err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  assign regs_o = r_regs;

endmodule

// File: tb/tb_spi_cmd_regbank.sv
module tb_spi_cmd_regbank;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          frame_active = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [N*8-1:0] regs_o;
  logic          wr_strobe;
  logic [6:0]    wr_addr;
  logic [7:0]    err_count;

  spi_cmd_regbank #(.NUM_REGS(N), .RESET_VALUE(8'h00), .ERR_BYTE(8'hEE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_active (frame_active),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .regs_o       (regs_o),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum {M_CMD, M_WR, M_RD, M_DROP} mode_t;
  mode_t      m_mode = M_CMD;
  int         m_addr = 0;
  logic [7:0] m_regs [N];
  int         m_err = 0;
  logic       m_prev_fa = 1'b0;
  logic       e_txv = 1'b0;
  logic [7:0] e_txd = 8'h00;
  logic       e_wrs = 1'b0;
  logic [6:0] e_wra = 7'd0;

  task automatic model_reset();
    m_mode = M_CMD; m_addr = 0; m_err = 0; m_prev_fa = 1'b0;
    e_txv = 1'b0; e_txd = 8'h00; e_wrs = 1'b0; e_wra = 7'd0;
    for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
  endtask

  task automatic model_step();
    bit fe;
    int a;
    fe = m_prev_fa && !frame_active;
    m_prev_fa = frame_active;
    e_txv = 1'b0;
    e_wrs = 1'b0;
    if (rx_valid) begin
      case (m_mode)
        M_CMD: begin
          a = int'(rx_data[6:0]);
          if (a >= N) begin
            m_mode = M_DROP;
            m_err  = (m_err < 255) ? m_err + 1 : 255;
            e_txv  = 1'b1; e_txd = 8'hEE;
          end else if (rx_data[7]) begin
            m_mode = M_WR; m_addr = a;
          end else begin
            m_mode = M_RD;
            e_txv  = 1'b1; e_txd = m_regs[a];
            m_addr = (a + 1) % N;
          end
        end
        M_WR: begin
          m_regs[m_addr] = rx_data;
          e_wrs = 1'b1; e_wra = 7'(m_addr);
          m_addr = (m_addr + 1) % N;
        end
        M_RD: begin
          e_txv = 1'b1; e_txd = m_regs[m_addr];
          m_addr = (m_addr + 1) % N;
        end
        default: ;
      endcase
    end
    if (fe) m_mode = M_CMD;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < N; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  // ---------------- per-cycle compare + pulse log ----------------
  logic [7:0] tx_q[$];
  logic [6:0] wr_q[$];

  initial begin
    forever begin
      @(negedge clk);
      check("tx_valid",  64'(tx_valid),  64'(e_txv));
      check("tx_data",   64'(tx_data),   64'(e_txd));
      check("wr_strobe", 64'(wr_strobe), 64'(e_wrs));
      check("wr_addr",   64'(wr_addr),   64'(e_wra));
      check("err_count", 64'(err_count), 64'(m_err));
      check("regs_o",    regs_o,         model_flat());
      if (tx_valid)  tx_q.push_back(tx_data);
      if (wr_strobe) wr_q.push_back(wr_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_begin();
    @(negedge clk); frame_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_finish();
    @(negedge clk); frame_active = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_logs();
    tx_q.delete();
    wr_q.delete();
  endtask

  logic [63:0] saved_regs;

  initial begin
    repeat (3) @(negedge clk);
    check("reset tx_data",   64'(tx_data),   64'h00);
    check("reset err_count", 64'(err_count), 64'h00);
    check("reset regs_o",    regs_o,         64'h0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write burst
    clear_logs();
    frame_begin(); send_byte(8'h81); send_byte(8'hAA); send_byte(8'h55); frame_finish();
    check("wb reg1",     64'(regs_o[15:8]),  64'hAA);
    check("wb reg2",     64'(regs_o[23:16]), 64'h55);
    check("wb wr count", 64'(wr_q.size()),   64'd2);
    if (wr_q.size() == 2) begin
      check("wb wr_addr0", 64'(wr_q[0]), 64'd1);
      check("wb wr_addr1", 64'(wr_q[1]), 64'd2);
    end
    check("wb no tx", 64'(tx_q.size()), 64'd0);

    // Read burst
    clear_logs();
    frame_begin(); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); frame_finish();
    check("rb tx count", 64'(tx_q.size()), 64'd3);
    if (tx_q.size() == 3) begin
      check("rb tx0", 64'(tx_q[0]), 64'hAA);
      check("rb tx1", 64'(tx_q[1]), 64'h55);
      check("rb tx2", 64'(tx_q[2]), 64'h00);
    end

    // Address wrap
    clear_logs();
    frame_begin(); send_byte(8'h87); send_byte(8'h11); send_byte(8'h22); frame_finish();
    check("wrap reg7", 64'(regs_o[63:56]), 64'h11);
    check("wrap reg0", 64'(regs_o[7:0]),   64'h22);
    if (wr_q.size() == 2) check("wrap wr_addr1", 64'(wr_q[1]), 64'd0);
    else check("wrap wr count", 64'(wr_q.size()), 64'd2);

    // Illegal address
    clear_logs();
    saved_regs = regs_o;
    frame_begin(); send_byte(8'h0A); send_byte(8'h00); frame_finish();
    check("ill tx count", 64'(tx_q.size()), 64'd1);
    if (tx_q.size() == 1) check("ill tx0", 64'(tx_q[0]), 64'hEE);
    check("ill err_count", 64'(err_count), 64'd1);
    check("ill regs",      regs_o,         saved_regs);
    for (int i = 0; i < 255; i++) begin
      frame_begin(); send_byte(8'h0A); frame_finish();
    end
    check("ill err sat", 64'(err_count), 64'd255);

    // Frame abort before the data byte
    clear_logs();
    frame_begin(); send_byte(8'h83); frame_finish();
    frame_begin(); send_byte(8'h03); send_byte(8'h00); frame_finish();
    check("abort tx count", 64'(tx_q.size()), 64'd2);
    if (tx_q.size() == 2) check("abort tx0", 64'(tx_q[0]), 64'h00);
    check("abort reg3",   64'(regs_o[31:24]), 64'h00);
    check("abort no wr",  64'(wr_q.size()),   64'd0);

    // Data byte on the frame-end cycle, then a byte outside any frame
    clear_logs();
    frame_begin(); send_byte(8'h84);
    @(negedge clk);
    rx_data = 8'h77; rx_valid = 1'b1; frame_active = 1'b0;
    @(negedge clk); rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h04);
    check("edge reg4", 64'(regs_o[39:32]), 64'h77);
    check("edge tx count", 64'(tx_q.size()), 64'd1);
    if (tx_q.size() == 1) check("edge tx0", 64'(tx_q[0]), 64'h77);

    // Async reset mid-WRITE
    frame_begin(); send_byte(8'h86); send_byte(8'h99);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst regs",     regs_o,          64'h0);
    check("arst tx_valid", 64'(tx_valid),   64'd0);
    check("arst err",      64'(err_count),  64'd0);
    frame_active = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    frame_begin(); send_byte(8'h82); send_byte(8'h5A); frame_finish();
    check("arst reg2", 64'(regs_o[23:16]), 64'h5A);
    check("arst regs other", regs_o & ~64'h0000_0000_00FF_0000, 64'h0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
